// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor.
// One decimal digit is resolved per clock, least significant digit first.
// Subtraction adds the nine's complement of B plus an initial carry, giving
// a ten's-complement result whenever a borrow leaves the top digit.
module bcd_serial_addsub #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  mode,
  input  logic                  cin,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  // Captured operands and running carry (data path, no reset needed)
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic             r_mode;
  logic             r_carry;

  // Result and control registers
  logic [IDX_W-1:0] r_idx;
  logic [W-1:0]     r_sum;
  logic             r_cout;
  logic             r_err;

  // Per-digit combinational signals
  logic             w_accept;
  logic             w_step;
  logic             w_last;
  logic [3:0]       w_a_dig;
  logic [3:0]       w_b_dig;
  logic [3:0]       w_b_adj;
  logic [4:0]       w_t;
  logic [4:0]       w_t6;
  logic             w_gt9;
  logic [3:0]       w_digit;
  logic             w_carry_nxt;
  logic             w_bad_dig;

  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_step   = (r_state == RUN);
  assign w_last   = (r_idx == LAST_IDX);

  // Select the digit pair addressed by the current index
  always_comb begin
    w_a_dig = '0;
    w_b_dig = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_a_dig = r_a[4*k +: 4];
        w_b_dig = r_b[4*k +: 4];
      end
    end
  end

  // One BCD digit add with decimal correction; 9-b wraps mod 16 for bad digits
  always_comb begin
    w_b_adj     = r_mode ? (4'd9 - w_b_dig) : w_b_dig;
    w_t         = {1'b0, w_a_dig} + {1'b0, w_b_adj} + {4'b0000, r_carry};
    w_t6        = w_t + 5'd6;
    w_gt9       = (w_t > 5'd9);
    w_digit     = w_gt9 ? w_t6[3:0] : w_t[3:0];
    w_carry_nxt = w_gt9;
    w_bad_dig   = (w_a_dig > 4'd9) || (w_b_dig > 4'd9);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_nxt = RUN;
      RUN:     if (w_last)    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default:                w_state_nxt = IDLE;
    endcase
  end

  // Operand capture and carry propagation between digits
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_mode  <= mode;
      r_carry <= mode ? ~cin : cin;
    end else if (w_step) begin
      r_carry <= w_carry_nxt;
    end
  end

  // Digit index, result digits, carry-out and sticky error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_err  <= 1'b0;
    end else if (w_accept) begin
      r_idx  <= '0;
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_err  <= 1'b0;
    end else if (w_step) begin
      for (int k = 0; k < DIGITS; k++) begin
        if (r_idx == IDX_W'(k)) begin
          r_sum[4*k +: 4] <= w_digit;
        end
      end
      if (w_bad_dig) begin
        r_err <= 1'b1;
      end
      if (w_last) begin
        r_cout <= r_mode ? ~w_carry_nxt : w_carry_nxt;
      end else begin
        r_idx  <= r_idx + IDX_W'(1);
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign err       = r_err;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Directed bench for bcd_serial_addsub with DIGITS=4.
module tb_bcd_serial_addsub;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         mode;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         err;

  int n_vec = 0;
  int n_bad = 0;

  bcd_serial_addsub #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .cin       (cin),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an operation, check latency, then optionally drain the result
  task automatic run_op(input string tag, input logic m, input logic c,
                        input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] exp_sum, input logic exp_cout,
                        input logic exp_err, input logic drain);
    mode     = m;
    cin      = c;
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a        = 16'hFFFF;
    b        = 16'hFFFF;
    chk({tag, ".in_ready_run"}, 32'(in_ready), 32'd0);
    tick();
    tick();
    tick();
    chk({tag, ".early_valid"}, 32'(out_valid), 32'd0);
    tick();
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".sum"}, 32'(sum), 32'(exp_sum));
    chk({tag, ".cout"}, 32'(cout), 32'(exp_cout));
    chk({tag, ".err"}, 32'(err), 32'(exp_err));
    if (drain) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, ".drained"}, 32'(out_valid), 32'd0);
      chk({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mode      = 1'b0;
    cin       = 1'b0;
    a         = '0;
    b         = '0;
    tick();
    tick();
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.sum", 32'(sum), 32'd0);
    chk("rst.cout", 32'(cout), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    rst_n = 1'b1;
    tick();

    // plain addition
    run_op("add1", 1'b0, 1'b0, 16'h1234, 16'h5678, 16'h6912, 1'b0, 1'b0, 1'b1);
    // decimal wrap with carry out, then carry-in only
    run_op("addwrap", 1'b0, 1'b0, 16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op("addcin", 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b1);
    // subtraction without and with borrow, and with borrow-in
    run_op("sub1", 1'b1, 1'b0, 16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 1'b1);
    run_op("subneg", 1'b1, 1'b0, 16'h0003, 16'h0005, 16'h9998, 1'b1, 1'b0, 1'b1);
    run_op("subbin", 1'b1, 1'b1, 16'h0100, 16'h0001, 16'h0098, 1'b0, 1'b0, 1'b1);
    // invalid digit: A0 -> digit 0 with carry into the hundreds
    run_op("baddig", 1'b0, 1'b0, 16'h00A0, 16'h0000, 16'h0100, 1'b0, 1'b1, 1'b1);
    run_op("errclr", 1'b0, 1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1);

    // backpressure: result held, new requests ignored
    run_op("bp", 1'b0, 1'b0, 16'h4321, 16'h1111, 16'h5432, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    mode     = 1'b0;
    a        = 16'h0007;
    b        = 16'h0002;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("bp.out_valid", 32'(out_valid), 32'd1);
      chk("bp.in_ready", 32'(in_ready), 32'd0);
      chk("bp.sum", 32'(sum), 32'h5432);
      chk("bp.cout", 32'(cout), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp.release_valid", 32'(out_valid), 32'd0);
    chk("bp.release_ready", 32'(in_ready), 32'd1);
    chk("bp.sum_kept", 32'(sum), 32'h5432);
    tick();
    chk("bp.no_capture", 32'(in_ready), 32'd1);

    // reset in the middle of a run
    mode     = 1'b0;
    cin      = 1'b0;
    a        = 16'h1234;
    b        = 16'h5678;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst.out_valid", 32'(out_valid), 32'd0);
    chk("midrst.in_ready", 32'(in_ready), 32'd1);
    chk("midrst.sum", 32'(sum), 32'd0);
    chk("midrst.cout", 32'(cout), 32'd0);
    chk("midrst.err", 32'(err), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("midrst.ready_after", 32'(in_ready), 32'd1);
    chk("midrst.valid_after", 32'(out_valid), 32'd0);
    run_op("postrst", 1'b0, 1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
